// File: rtl/bicubic_line_feeder.sv
// bicubic_line_feeder: raster line-buffer front end producing 4-row columns
// for a bicubic 4x4 window core, with top-border masking and frame control.
`default_nettype none

module bicubic_line_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int COL_BITS   = 6,
  parameter int ROW_BITS   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] pix_in,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic [DATA_WIDTH-1:0] row0_out,
  output logic [DATA_WIDTH-1:0] row1_out,
  output logic [DATA_WIDTH-1:0] row2_out,
  output logic [DATA_WIDTH-1:0] row3_out,
  output logic                  shift_window,
  output logic                  window_valid,
  output logic [COL_BITS-1:0]   out_col,
  output logic [ROW_BITS-1:0]   out_row,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int DEPTH = 2 ** COL_BITS;
  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(IMG_WIDTH - 1);
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(IMG_HEIGHT - 1);
  localparam logic [COL_BITS-1:0] COL_THREE = COL_BITS'(3);
  localparam logic [ROW_BITS-1:0] ROW_ONE   = ROW_BITS'(1);
  localparam logic [ROW_BITS-1:0] ROW_TWO   = ROW_BITS'(2);
  localparam logic [ROW_BITS-1:0] ROW_THREE = ROW_BITS'(3);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state;

  logic [COL_BITS-1:0]   col;
  logic [ROW_BITS-1:0]   row;
  logic [DATA_WIDTH-1:0] lb0 [DEPTH];
  logic [DATA_WIDTH-1:0] lb1 [DEPTH];
  logic [DATA_WIDTH-1:0] lb2 [DEPTH];
  logic [DATA_WIDTH-1:0] rd0;
  logic [DATA_WIDTH-1:0] rd1;
  logic [DATA_WIDTH-1:0] rd2;
  logic                  accept;
  logic                  last_pix;

  assign pix_ready = (state == ACTIVE);
  assign accept    = pix_valid && pix_ready;
  assign last_pix  = (col == LAST_COL) && (row == LAST_ROW);

  // Read-before-write: these are the pre-write contents at the current column.
  assign rd0 = lb0[col];
  assign rd1 = lb1[col];
  assign rd2 = lb2[col];

  // RAM is deliberately unreset; stale lines are hidden by top-border masking.
  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      lb0[col] <= pix_in;
      lb1[col] <= rd0;
      lb2[col] <= rd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      row0_out     <= '0;
      row1_out     <= '0;
      row2_out     <= '0;
      row3_out     <= '0;
      shift_window <= 1'b0;
      window_valid <= 1'b0;
      out_col      <= '0;
      out_row      <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      shift_window <= 1'b0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;

      if (accept) begin
        row3_out     <= pix_in;
        row2_out     <= (row >= ROW_ONE)   ? rd0 : '0;
        row1_out     <= (row >= ROW_TWO)   ? rd1 : '0;
        row0_out     <= (row >= ROW_THREE) ? rd2 : '0;
        shift_window <= 1'b1;
        window_valid <= (row >= ROW_THREE) && (col >= COL_THREE);
        out_col      <= col;
        out_row      <= row;
        if (col == LAST_COL) begin
          col <= '0;
          row <= (row == LAST_ROW) ? '0 : row + ROW_ONE;
        end else begin
          col <= col + COL_BITS'(1);
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state <= ACTIVE;
            col   <= '0;
            row   <= '0;
            busy  <= 1'b1;
          end
        end
        ACTIVE: begin
          if (accept && last_pix) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
